// File: rtl/dual_path_add_sched_pkg.sv
// Shared definitions for the dual-path adder scheduler: default sizes, FSM codes,
// requester ids, the tag-pipe entry type and small operand helpers.
package dual_path_add_sched_pkg;

    localparam int SIZE_MANTISSA_D = 24;
    localparam int SIZE_EXPONENT_D = 8;
    localparam int LATENCY_D       = 4;
    localparam int FIFO_DEPTH_D    = 4;

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_DRAIN = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    function automatic logic f_eff_sub(input logic sub, input logic sign_a, input logic sign_b);
        return sub ^ sign_a ^ sign_b;
    endfunction

    function automatic logic f_even_parity2(input logic [1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/dual_path_add_sched_if.sv
// Handshake bundle between the scheduler and its environment (requesters, adder, consumers).
interface dual_path_add_sched_if #(
    parameter int SIZE_WORD = 32
);
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [SIZE_WORD-1:0] req_a0;
    logic [SIZE_WORD-1:0] req_b0;
    logic [SIZE_WORD-1:0] req_a1;
    logic [SIZE_WORD-1:0] req_b1;
    logic [1:0]           req_sub;
    logic                 adder_in_valid;
    logic [SIZE_WORD-1:0] adder_a;
    logic [SIZE_WORD-1:0] adder_b;
    logic                 adder_eff_sub;
    logic                 adder_near;
    logic [SIZE_WORD-1:0] adder_res;
    logic [1:0]           res_valid;
    logic [1:0]           res_ready;
    logic [SIZE_WORD-1:0] res_data0;
    logic [SIZE_WORD-1:0] res_data1;
    logic                 flush;
    logic                 flush_done;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_sub,
        output adder_res, res_ready, flush,
        input  req_ready, adder_in_valid, adder_a, adder_b, adder_eff_sub, adder_near,
        input  res_valid, res_data0, res_data1, flush_done
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_sub,
        input  adder_res, res_ready, flush,
        output req_ready, adder_in_valid, adder_a, adder_b, adder_eff_sub, adder_near,
        output res_valid, res_data0, res_data1, flush_done
    );

endinterface

// File: rtl/dual_path_add_sched_fifo.sv
// Per-requester result FIFO with a registered head word, plus its overflow checker.
module sched_result_fifo #(
    parameter int SIZE_WORD  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_push,
    input  logic [SIZE_WORD-1:0]               i_wdata,
    input  logic                               i_pop,
    output logic                               o_valid,
    output logic [SIZE_WORD-1:0]               o_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    logic [SIZE_WORD-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_valid;
    logic [SIZE_WORD-1:0] r_head;

    logic                 w_pop;
    logic [PTR_W-1:0]     w_rd_next;
    logic [CNT_W-1:0]     w_count_next;
    logic [SIZE_WORD-1:0] w_head_next;

    assign w_pop     = i_pop & r_valid;
    assign w_rd_next = r_rd_ptr + PTR_W'(1);

    // Next occupancy and next head; the head comes from storage unless the FIFO runs dry.
    always_comb begin
        w_count_next = r_count;
        w_head_next  = r_head;
        if (i_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!i_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end else begin
            w_count_next = r_count;
        end
        if (w_pop) begin
            if (r_count > CNT_W'(1)) begin
                w_head_next = r_mem[w_rd_next];
            end else if (i_push) begin
                w_head_next = i_wdata;
            end else begin
                w_head_next = r_head;
            end
        end else if (i_push && !r_valid) begin
            w_head_next = i_wdata;
        end else begin
            w_head_next = r_head;
        end
    end

    // Storage array write.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);
            r_head  <= w_head_next;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_head;
    assign o_count = r_count;

    sched_result_fifo_chk #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_push),
        .i_count (r_count)
    );

endmodule

module sched_result_fifo_chk #(
    parameter int CNT_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input logic             i_clk,
    input logic             i_rst,
    input logic             i_push,
    input logic [CNT_W-1:0] i_count
);

    // Credits bound occupancy, so a push into a full FIFO means the accounting broke.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            assert (!(i_push && (i_count == CNT_W'(FIFO_DEPTH))));
        end
    end

endmodule

// File: rtl/dual_path_add_sched.sv
// Two-requester front end for a shared fixed-latency dual-path FP adder:
// round-robin arbitration, near/far path select, tag pipe, credited result FIFOs and drain FSM.
module dual_path_add_sched
    import dual_path_add_sched_pkg::*;
#(
    parameter int SIZE_MANTISSA = SIZE_MANTISSA_D,
    parameter int SIZE_EXPONENT = SIZE_EXPONENT_D,
    parameter int LATENCY       = LATENCY_D,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_D
) (
    input logic                   i_clk,
    input logic                   i_rst,
    dual_path_add_sched_if.slave  io_bus
);

    localparam int SW    = SIZE_EXPONENT + SIZE_MANTISSA;
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int EW1   = SIZE_EXPONENT + 1;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic                   r_rr_last;
    logic [CNT_W-1:0]       r_credit [2];

    logic                   w_run;
    logic [1:0]             w_elig;
    logic [1:0]             w_grant;
    logic                   w_grant_any;
    logic                   w_grant_id;
    logic [SW-1:0]          w_sel_a;
    logic [SW-1:0]          w_sel_b;
    logic                   w_sel_sub;
    logic [SIZE_EXPONENT-1:0] w_exp_a;
    logic [SIZE_EXPONENT-1:0] w_exp_b;
    logic [EW1-1:0]         w_exp_diff;
    logic                   w_eff_sub;
    logic                   w_near;

    logic                   r_issue_v;
    logic                   r_issue_id;
    logic [SW-1:0]          r_adder_a;
    logic [SW-1:0]          r_adder_b;
    logic                   r_eff_sub;
    logic                   r_near;

    tag_t                   r_tag [LATENCY];
    logic                   w_tag_busy;
    logic [1:0]             w_push;
    logic [1:0]             w_pop;
    logic [1:0]             w_res_valid;
    logic [SW-1:0]          w_res_data0;
    logic [SW-1:0]          w_res_data1;
    logic [CNT_W-1:0]       w_fifo_count0;
    logic [CNT_W-1:0]       w_fifo_count1;
    logic [1:0]             w_fifo_clear;
    logic                   w_drained;

    // Grants only in RUN, never in the cycle flush is first seen, never while reset is applied.
    assign w_run     = i_rst & (r_state == ST_RUN) & ~io_bus.flush;
    assign w_elig[0] = io_bus.req_valid[0] & (r_credit[0] != '0) & w_run;
    assign w_elig[1] = io_bus.req_valid[1] & (r_credit[1] != '0) & w_run;

    // Round-robin pick: a tie goes to the requester that was not granted last.
    always_comb begin
        w_grant = 2'b00;
        case (w_elig)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_rr_last ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    assign w_grant_any = |w_grant;
    assign w_grant_id  = w_grant[1];
    assign w_sel_a     = w_grant_id ? io_bus.req_a1 : io_bus.req_a0;
    assign w_sel_b     = w_grant_id ? io_bus.req_b1 : io_bus.req_b0;
    assign w_sel_sub   = w_grant_id ? io_bus.req_sub[1] : io_bus.req_sub[0];
    assign w_exp_a     = w_sel_a[SW-2 -: SIZE_EXPONENT];
    assign w_exp_b     = w_sel_b[SW-2 -: SIZE_EXPONENT];
    assign w_eff_sub   = f_eff_sub(w_sel_sub, w_sel_a[SW-1], w_sel_b[SW-1]);

    // Absolute exponent distance; near path only for an effective subtract within one binade.
    always_comb begin
        w_exp_diff = '0;
        if (w_exp_a >= w_exp_b) begin
            w_exp_diff = {1'b0, w_exp_a} - {1'b0, w_exp_b};
        end else begin
            w_exp_diff = {1'b0, w_exp_b} - {1'b0, w_exp_a};
        end
    end

    assign w_near = w_eff_sub & (w_exp_diff <= EW1'(1));

    // Issue register: the adder sees the granted operands one cycle after the grant.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_issue_v  <= 1'b0;
            r_issue_id <= 1'b0;
            r_adder_a  <= '0;
            r_adder_b  <= '0;
            r_eff_sub  <= 1'b0;
            r_near     <= 1'b0;
        end else begin
            r_issue_v <= w_grant_any;
            if (w_grant_any) begin
                r_issue_id <= w_grant_id;
                r_adder_a  <= w_sel_a;
                r_adder_b  <= w_sel_b;
                r_eff_sub  <= w_eff_sub;
                r_near     <= w_near;
            end
        end
    end

    // Tag pipe follows each issued op so its result can be steered when the adder answers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0].valid <= r_issue_v;
            r_tag[0].id    <= r_issue_id;
            for (int k = 1; k < LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // Any op between issue and FIFO push.
    always_comb begin
        w_tag_busy = r_issue_v;
        for (int k = 0; k < LATENCY; k++) begin
            w_tag_busy = w_tag_busy | r_tag[k].valid;
        end
    end

    assign w_push[0] = r_tag[LATENCY-1].valid & (r_tag[LATENCY-1].id == REQ_ID0);
    assign w_push[1] = r_tag[LATENCY-1].valid & (r_tag[LATENCY-1].id == REQ_ID1);
    assign w_pop     = io_bus.res_ready & w_res_valid;

    // Credits: one per FIFO slot, spent on grant and returned on pop.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!i_rst) begin
                r_credit[i] <= CNT_W'(FIFO_DEPTH);
            end else if (w_grant[i] && !w_pop[i]) begin
                r_credit[i] <= r_credit[i] - CNT_W'(1);
            end else if (!w_grant[i] && w_pop[i]) begin
                r_credit[i] <= r_credit[i] + CNT_W'(1);
            end
        end
    end

    // Round-robin history, advanced only when something is granted.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_rr_last <= 1'b1;
        end else if (w_grant_any) begin
            r_rr_last <= w_grant_id;
        end
    end

    // A FIFO counts as empty if it is empty now or its last entry is popped this cycle.
    assign w_fifo_clear[0] = (w_fifo_count0 == '0) | ((w_fifo_count0 == CNT_W'(1)) & w_pop[0]);
    assign w_fifo_clear[1] = (w_fifo_count1 == '0) | ((w_fifo_count1 == CNT_W'(1)) & w_pop[1]);
    assign w_drained       = ~w_tag_busy & (&w_fifo_clear);

    // Drain FSM next state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (io_bus.flush) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_drained) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (io_bus.flush) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // Drain FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    sched_result_fifo #(
        .SIZE_WORD  (SW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo0 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push[0]),
        .i_wdata (io_bus.adder_res),
        .i_pop   (io_bus.res_ready[0]),
        .o_valid (w_res_valid[0]),
        .o_data  (w_res_data0),
        .o_count (w_fifo_count0)
    );

    sched_result_fifo #(
        .SIZE_WORD  (SW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push[1]),
        .i_wdata (io_bus.adder_res),
        .i_pop   (io_bus.res_ready[1]),
        .o_valid (w_res_valid[1]),
        .o_data  (w_res_data1),
        .o_count (w_fifo_count1)
    );

    assign io_bus.req_ready      = w_grant;
    assign io_bus.adder_in_valid = r_issue_v;
    assign io_bus.adder_a        = r_adder_a;
    assign io_bus.adder_b        = r_adder_b;
    assign io_bus.adder_eff_sub  = r_eff_sub;
    assign io_bus.adder_near     = r_near;
    assign io_bus.res_valid      = w_res_valid;
    assign io_bus.res_data0      = w_res_data0;
    assign io_bus.res_data1      = w_res_data1;
    assign io_bus.flush_done     = i_rst & (r_state == ST_DONE) & io_bus.flush;

endmodule

// File: tb/tb_dual_path_add_sched.sv
// Directed bench for dual_path_add_sched with a behavioural A+B adder of latency 4.
module tb_dual_path_add_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dual_path_add_sched_if #(.SIZE_WORD(32)) bus ();

    dual_path_add_sched dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Adder model: result of an issue appears on adder_res exactly 4 cycles later.
    logic [31:0] dl [4];
    always @(posedge clk) begin
        dl[0] <= bus.adder_in_valid ? (bus.adder_a + bus.adder_b) : 32'hDEAD_BEEF;
        for (int k = 1; k < 4; k++) dl[k] <= dl[k-1];
    end
    assign bus.adder_res = dl[3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] st_a(input int c);
        return (((c % 2) == 0) ? 32'h1000_0000 : 32'h2000_0000) | 32'(c);
    endfunction

    function automatic logic [31:0] st_b(input int c);
        return (((c % 2) == 0) ? 32'h0200_0000 : 32'h0300_0000) | (32'(c) << 8);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid = 2'b11; bus.req_sub = 2'b00; bus.res_ready = 2'b00; bus.flush = 1'b0;
        bus.req_a0 = 32'h0; bus.req_b0 = 32'h0; bus.req_a1 = 32'h0; bus.req_b1 = 32'h0;

        // Reset: everything quiet even with both requests raised.
        step(); step();
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_issue", 32'(bus.adder_in_valid), 32'h0);
        check("rst_res_valid", 32'(bus.res_valid), 32'h0);
        check("rst_flush_done", 32'(bus.flush_done), 32'h0);

        // Streaming: grants alternate 0,1,...; each result shows up 6 cycles after its grant.
        bus.res_ready = 2'b11;
        for (int c = 0; c < 15; c++) begin
            step();
            rst = 1'b1;
            bus.req_valid = (c < 8) ? 2'b11 : 2'b00;
            bus.req_a0 = st_a(2 * (c / 2));     bus.req_b0 = st_b(2 * (c / 2));
            bus.req_a1 = st_a(2 * (c / 2) + 1); bus.req_b1 = st_b(2 * (c / 2) + 1);
            if ((c % 2) == 1) begin
                bus.req_a0 = st_a(c + 1); bus.req_b0 = st_b(c + 1);
                bus.req_a1 = st_a(c);     bus.req_b1 = st_b(c);
            end
            #1;
            check("stream_ready", 32'(bus.req_ready), (c < 8) ? (((c % 2) == 0) ? 32'h1 : 32'h2) : 32'h0);
            if (c >= 1 && c <= 8) check("stream_issue_a", bus.adder_a, st_a(c - 1));
            if (c >= 6 && c < 14) begin
                check("stream_res_valid", 32'(bus.res_valid), ((c % 2) == 0) ? 32'h1 : 32'h2);
                check("stream_res_data", ((c % 2) == 0) ? bus.res_data0 : bus.res_data1,
                      st_a(c - 6) + st_b(c - 6));
            end else begin
                check("stream_res_idle", 32'(bus.res_valid), 32'h0);
            end
        end

        // Path select on requester 0.
        step(); bus.req_valid = 2'b01; bus.req_sub = 2'b01;
        bus.req_a0 = 32'h4040_0000; bus.req_b0 = 32'h4000_0000; #1;
        check("ps_ready", 32'(bus.req_ready), 32'h1);
        step(); bus.req_a0 = 32'h4100_0000; bus.req_b0 = 32'h3F80_0000; #1;
        check("ps1_valid", 32'(bus.adder_in_valid), 32'h1);
        check("ps1_eff", 32'(bus.adder_eff_sub), 32'h1);
        check("ps1_near", 32'(bus.adder_near), 32'h1);
        step(); bus.req_sub = 2'b00; bus.req_a0 = 32'h4040_0000; bus.req_b0 = 32'hC000_0000; #1;
        check("ps2_a", bus.adder_a, 32'h4100_0000);
        check("ps2_eff", 32'(bus.adder_eff_sub), 32'h1);
        check("ps2_near", 32'(bus.adder_near), 32'h0);
        step(); bus.req_b0 = 32'h4000_0000; #1;
        check("ps3_eff", 32'(bus.adder_eff_sub), 32'h1);
        check("ps3_near", 32'(bus.adder_near), 32'h1);
        step(); bus.req_valid = 2'b00; #1;
        check("ps4_eff", 32'(bus.adder_eff_sub), 32'h0);
        check("ps4_near", 32'(bus.adder_near), 32'h0);
        for (int i = 0; i < 10; i++) step();

        // Credit exhaustion on requester 0 (no pops).
        bus.res_ready = 2'b10; bus.req_b0 = 32'h0000_0100;
        for (int k = 0; k < 6; k++) begin
            step(); bus.req_valid = 2'b01; bus.req_a0 = 32'h1111_0000 + 32'(k); #1;
            check("cr_ready", 32'(bus.req_ready), (k < 4) ? 32'h1 : 32'h0);
        end
        step(); bus.req_valid = 2'b11; #1;
        check("cr_req1_ready", 32'(bus.req_ready), 32'h2);
        for (int i = 0; i < 8; i++) begin
            step(); bus.req_valid = 2'b01;
        end
        #1;
        check("cr_full_valid", 32'(bus.res_valid[0]), 32'h1);
        check("cr_head", bus.res_data0, 32'h1111_0100);
        step(); bus.res_ready = 2'b11; #1;
        check("cr_pop_ready", 32'(bus.req_ready), 32'h0);
        step(); bus.res_ready = 2'b10; #1;
        check("cr_regrant", 32'(bus.req_ready), 32'h1);
        check("cr_head2", bus.res_data0, 32'h1111_0101);
        step(); #1;
        check("cr_one_only", 32'(bus.req_ready), 32'h0);
        for (int i = 0; i < 7; i++) step();

        // Grant and pop together at credit 1: credit holds, no bubble.
        step(); bus.res_ready = 2'b11; #1;
        check("gp_ready0", 32'(bus.req_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            check("gp_ready", 32'(bus.req_ready), 32'h1);
        end
        step(); bus.req_valid = 2'b00;
        for (int i = 0; i < 12; i++) step();

        // Flush with 3 ops in flight.
        bus.res_ready = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step(); bus.req_valid = 2'b11;
        end
        step(); bus.flush = 1'b1; #1;
        check("fl_no_grant", 32'(bus.req_ready), 32'h0);
        check("fl_done_early", 32'(bus.flush_done), 32'h0);
        for (int i = 0; i < 10; i++) step();
        #1;
        check("fl_held", 32'(bus.res_valid), 32'h3);
        check("fl_hold_ready", 32'(bus.req_ready), 32'h0);
        step(); bus.res_ready = 2'b11; #1;
        check("fl_pop1_done", 32'(bus.flush_done), 32'h0);
        step(); #1;
        check("fl_pop2_done", 32'(bus.flush_done), 32'h0);
        step(); bus.res_ready = 2'b00; #1;
        check("fl_done", 32'(bus.flush_done), 32'h1);
        check("fl_done_ready", 32'(bus.req_ready), 32'h0);
        step(); bus.flush = 1'b0; #1;
        check("fl_release_done", 32'(bus.flush_done), 32'h0);
        check("fl_release_ready", 32'(bus.req_ready), 32'h0);
        step(); #1;
        check("fl_resume", 32'(bus.req_ready), 32'h1);
        bus.res_ready = 2'b11;
        step(); bus.req_valid = 2'b00;
        for (int i = 0; i < 10; i++) step();

        // Reset with 4 ops in flight.
        bus.res_ready = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step(); bus.req_valid = 2'b11;
        end
        step(); rst = 1'b0; #1;
        check("mr_ready_in_rst", 32'(bus.req_ready), 32'h0);
        step(); rst = 1'b1; bus.req_a0 = 32'h5000_0000; bus.req_b0 = 32'h0000_0005; #1;
        check("mr_issue", 32'(bus.adder_in_valid), 32'h0);
        check("mr_a", bus.adder_a, 32'h0);
        check("mr_eff", 32'(bus.adder_eff_sub), 32'h0);
        check("mr_near", 32'(bus.adder_near), 32'h0);
        check("mr_res_valid", 32'(bus.res_valid), 32'h0);
        check("mr_first_grant", 32'(bus.req_ready), 32'h1);
        step(); bus.req_valid = 2'b00; #1;
        check("mr_issue_a", bus.adder_a, 32'h5000_0000);
        for (int i = 0; i < 6; i++) step();
        #1;
        check("mr_no_stale", 32'(bus.res_valid), 32'h1);
        check("mr_data", bus.res_data0, 32'h5000_0005);
        step(); bus.res_ready = 2'b01;
        step(); bus.res_ready = 2'b00; #1;
        check("mr_empty", 32'(bus.res_valid), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(); bus.req_valid = 2'b01; #1;
            check("mr_credits", 32'(bus.req_ready), (k < 4) ? 32'h1 : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
